// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master request/done interface among
// NUM_REQ requesters; write and read channels are arbitrated independently.

module axil_arb_chan #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 32,
  parameter int RW      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    s_valid,
  output logic [NUM_REQ-1:0]    s_ready,
  input  logic [NUM_REQ*PW-1:0] s_payload,
  output logic [NUM_REQ-1:0]    s_done,
  output logic [RW-1:0]         s_resp,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PW-1:0]         m_payload,
  input  logic                  m_done,
  input  logic [RW-1:0]         m_resp
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        payload_q, payload_d;
  logic [RW-1:0]        resp_q, resp_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  always_comb begin
    int   idx;
    int   win;
    logic found;
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    payload_d = payload_q;
    resp_d    = resp_q;
    done_d    = '0;
    s_ready   = '0;
    found     = 1'b0;
    win       = 0;
    idx       = 0;
    case (state_q)
      IDLE: begin
        // Search starts one past the last winner so every requester gets a turn.
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (int'(ptr_q) + k) % NUM_REQ;
          if (!found && s_valid[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found && !rst) begin
          s_ready[win] = 1'b1;
          payload_d    = s_payload[win*PW +: PW];
          owner_d      = IW'(win);
          ptr_d        = IW'(win);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          if (m_done) begin
            resp_d          = m_resp;
            done_d[owner_q] = 1'b1;
            state_d         = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (m_done) begin
          resp_d          = m_resp;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NUM_REQ - 1);
      owner_q   <= '0;
      payload_q <= '0;
      resp_q    <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      payload_q <= payload_d;
      resp_q    <= resp_d;
      done_q    <= done_d;
    end
  end

  assign m_valid   = (state_q == ISSUE);
  assign m_payload = payload_q;
  assign s_done    = done_q;
  assign s_resp    = resp_q;
endmodule

module axil_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_REQ-1:0]                 s_wr_valid,
  output logic [NUM_REQ-1:0]                 s_wr_ready,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  s_wr_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]  s_wr_data,
  output logic [NUM_REQ-1:0]                 s_wr_done,
  output logic [1:0]                         s_wr_error,
  input  logic [NUM_REQ-1:0]                 s_rd_valid,
  output logic [NUM_REQ-1:0]                 s_rd_ready,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  s_rd_addr,
  output logic [NUM_REQ-1:0]                 s_rd_done,
  output logic [AXI_DATA_WIDTH-1:0]          s_rd_data,
  output logic [1:0]                         s_rd_error,
  output logic                               wr_valid,
  input  logic                               wr_ready,
  output logic [AXI_ADDR_WIDTH-1:0]          wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]          wr_data,
  input  logic                               wr_done,
  input  logic [1:0]                         wr_error,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [AXI_ADDR_WIDTH-1:0]          rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]          rd_data,
  input  logic                               rd_done,
  input  logic [1:0]                         rd_error
);
  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int WPW = AW + DW;

  logic [NUM_REQ*WPW-1:0] wr_req_pl;
  logic [WPW-1:0]         wr_pl;
  logic [DW+1:0]          rd_resp;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign wr_req_pl[i*WPW +: WPW] = {s_wr_addr[i*AW +: AW], s_wr_data[i*DW +: DW]};
  end

  axil_arb_chan #(.NUM_REQ(NUM_REQ), .PW(WPW), .RW(2)) u_wr (
    .clk       (aclk),
    .rst       (areset),
    .s_valid   (s_wr_valid),
    .s_ready   (s_wr_ready),
    .s_payload (wr_req_pl),
    .s_done    (s_wr_done),
    .s_resp    (s_wr_error),
    .m_valid   (wr_valid),
    .m_ready   (wr_ready),
    .m_payload (wr_pl),
    .m_done    (wr_done),
    .m_resp    (wr_error)
  );

  assign {wr_addr, wr_data} = wr_pl;

  // Read responses carry data back, so the response word is {error, data}.
  axil_arb_chan #(.NUM_REQ(NUM_REQ), .PW(AW), .RW(DW + 2)) u_rd (
    .clk       (aclk),
    .rst       (areset),
    .s_valid   (s_rd_valid),
    .s_ready   (s_rd_ready),
    .s_payload (s_rd_addr),
    .s_done    (s_rd_done),
    .s_resp    (rd_resp),
    .m_valid   (rd_valid),
    .m_ready   (rd_ready),
    .m_payload (rd_addr),
    .m_done    (rd_done),
    .m_resp    ({rd_error, rd_data})
  );

  assign {s_rd_error, s_rd_data} = rd_resp;
endmodule
